// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill engine: FSM state encoding and
// default block geometry.
package cache_pkg;

  // Default block geometry (the top exposes these as overridable parameters)
  localparam int BLOCK_WORDS = 8;
  localparam int WORD_BYTES  = 2;
  localparam int OFFSET_BITS = $clog2(BLOCK_WORDS * WORD_BYTES);

  // Fill FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_TAG  = 2'd2;

endpackage

// File: rtl/fill_counter.sv
// Word counter for one side of a block fill (requests or responses).
// 'last' flags the final word index; 'done' is sticky once the final word
// has been counted, so a caller can tell "all words issued" apart from
// "back at word 0" even though the count itself wraps.
module fill_counter #(
  parameter  int WORDS = 8,
  localparam int CNT_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  // Next count: clear wins over enable; done latches on the final increment
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
      if (count_q == LAST_IDX) begin
        done_d = 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_IDX);
  assign done  = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling engine: on a miss, requests every word of the block from
// memory, writes each returned word into the data array, then writes the tag.
// fsm_busy covers the whole fill so the controller steers the cache ports here.
// Optional build macro CACHE_FILL_STATS_EN adds saturating miss_count and
// fill_cycles outputs.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int WORD_BYTES  = cache_pkg::WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_data
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [15:0]       miss_count,
  output logic [15:0]       fill_cycles
`endif
);

  localparam int CNT_W    = $clog2(BLOCK_WORDS);
  localparam int WB_BITS  = $clog2(WORD_BYTES);
  localparam int OFF_BITS = $clog2(BLOCK_WORDS * WORD_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_BITS) - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic             in_idle, in_fill, in_tag;
  logic             start, req_fire, rsp_fire;
  logic [CNT_W-1:0] req_cnt, rsp_cnt;
  logic             req_done, req_last, rsp_done, rsp_last;
  logic [ADDR_W-1:0] req_off, rsp_off;
  logic             unused_cnt_flags;

  assign in_idle = (state_q == ST_IDLE);
  assign in_fill = (state_q == ST_FILL);
  assign in_tag  = (state_q == ST_TAG);

  assign start    = in_idle & miss_detected;
  assign req_fire = in_fill & ~req_done;
  assign rsp_fire = in_fill & mem_data_valid;

  // Offsets are always below the block size, so OR-ing them into the aligned
  // base can never carry into the tag bits.
  assign req_off = ADDR_W'(req_cnt) << WB_BITS;
  assign rsp_off = ADDR_W'(rsp_cnt) << WB_BITS;

  // Only the request side needs 'done' and only the response side needs 'last'
  assign unused_cnt_flags = req_last ^ rsp_done;

  fill_counter #(.WORDS(BLOCK_WORDS)) u_req_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (req_fire),
    .count  (req_cnt),
    .last   (req_last),
    .done   (req_done)
  );

  fill_counter #(.WORDS(BLOCK_WORDS)) u_rsp_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (rsp_fire),
    .count  (rsp_cnt),
    .last   (rsp_last),
    .done   (rsp_done)
  );

  // Next-state logic: latch the aligned block base on a miss, leave FILL on the last word
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address & ~OFF_MASK;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (rsp_fire && rsp_last) begin
          state_d = ST_TAG;
        end
      end
      ST_TAG:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and base registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Output decode; address/data buses are forced to zero whenever their strobe is low
  always_comb begin
    mem_read_en      = req_fire;
    mem_read_addr    = req_fire ? (base_q | req_off) : '0;
    fsm_busy         = in_fill | in_tag;
    write_data_array = rsp_fire;
    write_tag_array  = in_tag;
    memory_data      = rsp_fire ? mem_data_in : '0;
    if (rsp_fire) begin
      memory_address = base_q | rsp_off;
    end else if (in_tag) begin
      memory_address = base_q;
    end else begin
      memory_address = '0;
    end
  end

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] miss_count_q, miss_count_d;
  logic [15:0] fill_cycles_q, fill_cycles_d;

  // Saturating statistics counters
  always_comb begin
    miss_count_d  = miss_count_q;
    fill_cycles_d = fill_cycles_q;
    if (start && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
    if ((in_fill || in_tag) && (fill_cycles_q != 16'hFFFF)) begin
      fill_cycles_d = fill_cycles_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count_q  <= '0;
      fill_cycles_q <= '0;
    end else begin
      miss_count_q  <= miss_count_d;
      fill_cycles_q <= fill_cycles_d;
    end
  end

  assign miss_count  = miss_count_q;
  assign fill_cycles = fill_cycles_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a vector table for the basic fill,
// hand-written reset/stray-valid sequences and randomized fills checked
// against a behavioural model with a latency-programmable memory responder.
module tb_cache_fill_fsm;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_read_en;
  logic [15:0] mem_read_addr;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] miss_count;
  logic [15:0] fill_cycles;
`endif

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(BW), .WORD_BYTES(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem_data_in      (mem_data_in),
    .mem_data_valid   (mem_data_valid),
    .mem_read_en      (mem_read_en),
    .mem_read_addr    (mem_read_addr),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .memory_address   (memory_address),
    .memory_data      (memory_data)
`ifdef CACHE_FILL_STATS_EN
    ,
    .miss_count       (miss_count),
    .fill_cycles      (fill_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, " busy"},     16'(fsm_busy), 16'h0);
    chk({pfx, " rd_en"},    16'(mem_read_en), 16'h0);
    chk({pfx, " rd_addr"},  mem_read_addr, 16'h0);
    chk({pfx, " wr_data"},  16'(write_data_array), 16'h0);
    chk({pfx, " wr_tag"},   16'(write_tag_array), 16'h0);
    chk({pfx, " mem_addr"}, memory_address, 16'h0);
    chk({pfx, " mem_data"}, memory_data, 16'h0);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_fill, m_tag;
  logic [15:0] m_base;
  int          m_req, m_rsp;
  int          m_busy_cnt;
  int          cyc_n;

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } mreq_t;
  mreq_t memq[$];
  int    lat;
  bit    burst;
  int    gap_left;
  int    seen_wr, seen_tag;

  // One clock cycle driven and checked against the model
  task automatic tick(input bit miss, input logic [15:0] addr, input bit stray);
    bit          e_busy, e_rd, e_wr, v;
    logic [15:0] e_rd_addr, e_maddr, e_mdata, d;
    @(negedge clk);
    e_busy    = m_fill || m_tag;
    e_rd      = m_fill && (m_req < BW);
    e_rd_addr = e_rd ? m_base + 16'(m_req * 2) : 16'h0;
    if (e_rd) memq.push_back('{e_rd_addr, cyc_n + lat});
    v = 1'b0;
    d = 16'h0;
    if (m_fill && memq.size() > 0 && memq[0].ready <= cyc_n) begin
      if (gap_left > 0) begin
        gap_left--;
      end else begin
        v = 1'b1;
        d = memq[0].addr ^ 16'h5A5A;
        void'(memq.pop_front());
        gap_left = burst ? int'($urandom_range(0, 3)) : 0;
      end
    end else if (stray && !m_fill) begin
      v = 1'b1;
      d = 16'($urandom);
    end
    e_wr    = m_fill && v;
    e_maddr = e_wr ? m_base + 16'(m_rsp * 2) : (m_tag ? m_base : 16'h0);
    e_mdata = e_wr ? d : 16'h0;

    miss_detected  = miss;
    miss_address   = addr;
    mem_data_valid = v;
    mem_data_in    = d;
    #1;
    chk($sformatf("cyc%0d busy", cyc_n),     16'(fsm_busy), 16'(e_busy));
    chk($sformatf("cyc%0d rd_en", cyc_n),    16'(mem_read_en), 16'(e_rd));
    chk($sformatf("cyc%0d rd_addr", cyc_n),  mem_read_addr, e_rd_addr);
    chk($sformatf("cyc%0d wr_data", cyc_n),  16'(write_data_array), 16'(e_wr));
    chk($sformatf("cyc%0d wr_tag", cyc_n),   16'(write_tag_array), 16'(m_tag));
    chk($sformatf("cyc%0d mem_addr", cyc_n), memory_address, e_maddr);
    chk($sformatf("cyc%0d mem_data", cyc_n), memory_data, e_mdata);
    if (write_data_array) seen_wr++;
    if (write_tag_array)  seen_tag++;

    @(posedge clk);
    if (e_busy) m_busy_cnt++;
    if (m_tag) begin
      m_tag = 1'b0;
    end else if (m_fill) begin
      if (e_rd) m_req++;
      if (e_wr) begin
        m_rsp++;
        if (m_rsp == BW) begin
          m_fill = 1'b0;
          m_tag  = 1'b1;
        end
      end
    end else if (miss) begin
      m_fill = 1'b1;
      m_base = addr & 16'hFFF0;
      m_req  = 0;
      m_rsp  = 0;
    end
    cyc_n++;
  endtask

  task automatic run_fill(input logic [15:0] addr, input int l, input bit b);
    int n;
    lat = l;
    burst = b;
    gap_left = 0;
    seen_wr = 0;
    seen_tag = 0;
    tick(1'b1, addr, 1'b0);
    n = 0;
    while ((m_fill || m_tag) && n < 300) begin
      tick(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      n++;
    end
    chk($sformatf("fill %h in bound", addr), 16'(n < 300), 16'h1);
    chk($sformatf("fill %h data writes", addr), 16'(seen_wr), 16'(BW));
    chk($sformatf("fill %h tag writes", addr), 16'(seen_tag), 16'h1);
    $display("[TB] fill base=%h latency=%0d bursty=%0d cycles=%0d", addr & 16'hFFF0, l, b, n + 1);
  endtask

  task automatic async_reset(input string pfx);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero(pfx);
    m_fill = 1'b0;
    m_tag = 1'b0;
    memq.delete();
    gap_left = 0;
    m_busy_cnt = 0;
    miss_detected = 1'b0;
    mem_data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          miss;
    logic [15:0] addr;
    bit          valid;
    logic [15:0] data;
    bit          busy;
    bit          rd;
    logic [15:0] rd_addr;
    bit          wr;
    logic [15:0] maddr;
    logic [15:0] mdata;
    bit          tag;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int k;
    // idle with stray valid, then miss at 1236 with zero-latency memory
    vecs[0] = '{1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
    vecs[1] = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
    for (int i = 0; i < BW; i++) begin
      vecs[2+i] = '{1'b1, 16'h0000, 1'b1, 16'hA000 + 16'(i), 1'b1, 1'b1, 16'h1230 + 16'(2*i),
                    1'b1, 16'h1230 + 16'(2*i), 16'hA000 + 16'(i), 1'b0};
    end
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 1'b0, 16'h0, 1'b0, 16'h1230, 16'h0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0};

    m_fill = 1'b0; m_tag = 1'b0; m_base = 16'h0; m_req = 0; m_rsp = 0;
    m_busy_cnt = 0; cyc_n = 0; lat = 0; burst = 1'b0; gap_left = 0;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0;
    mem_data_in = 16'h0;
    mem_data_valid = 1'b0;
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table: basic fill at 1236 with data arriving every cycle
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      miss_detected  = vecs[k].miss;
      miss_address   = vecs[k].addr;
      mem_data_valid = vecs[k].valid;
      mem_data_in    = vecs[k].data;
      #1;
      chk($sformatf("vec%0d busy", k),     16'(fsm_busy), 16'(vecs[k].busy));
      chk($sformatf("vec%0d rd_en", k),    16'(mem_read_en), 16'(vecs[k].rd));
      chk($sformatf("vec%0d rd_addr", k),  mem_read_addr, vecs[k].rd_addr);
      chk($sformatf("vec%0d wr_data", k),  16'(write_data_array), 16'(vecs[k].wr));
      chk($sformatf("vec%0d mem_addr", k), memory_address, vecs[k].maddr);
      chk($sformatf("vec%0d mem_data", k), memory_data, vecs[k].mdata);
      chk($sformatf("vec%0d wr_tag", k),   16'(write_tag_array), 16'(vecs[k].tag));
      $display("[TB] vec%0d miss=%0d valid=%0d busy=%0d rd=%0d/%h wr=%0d/%h/%h tag=%0d", k,
               vecs[k].miss, vecs[k].valid, fsm_busy, mem_read_en, mem_read_addr,
               write_data_array, memory_address, memory_data, write_tag_array);
    end
    mem_data_valid = 1'b0;
    miss_detected = 1'b0;

    // Latency-4 fill, then a bursty fill
    run_fill(16'h1236, 4, 1'b0);
    run_fill(16'h4A5C, 2, 1'b1);

    // Reset after three data writes aborts the fill without a tag write
    lat = 1; burst = 1'b0; gap_left = 0; seen_wr = 0; seen_tag = 0;
    tick(1'b1, 16'h7778, 1'b0);
    for (int n = 0; n < 50 && m_rsp < 3; n++) tick(1'b0, 16'h0, 1'b0);
    chk("abort writes before reset", 16'(seen_wr), 16'h3);
    async_reset("mid-fill reset");
    chk("abort tag writes", 16'(seen_tag), 16'h0);
    tick(1'b0, 16'h0, 1'b0);
    run_fill(16'h2222, 3, 1'b0);

    // Stray valids in idle, then a fill at the top of the address space
    for (int n = 0; n < 3; n++) tick(1'b0, 16'h0, 1'b1);
    run_fill(16'hFFFE, 4, 1'b0);
    tick(1'b0, 16'h0, 1'b1);

    // Randomized back-to-back fills
    for (int n = 0; n < 20; n++) begin
      run_fill(16'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

`ifdef CACHE_FILL_STATS_EN
    async_reset("stats reset");
    chk("stats miss_count after reset", miss_count, 16'h0);
    chk("stats fill_cycles after reset", fill_cycles, 16'h0);
    run_fill(16'h0100, 4, 1'b0);
    run_fill(16'h0200, 4, 1'b0);
    @(negedge clk);
    chk("stats miss_count", miss_count, 16'd2);
    chk("stats fill_cycles", fill_cycles, 16'd26);
    chk("stats fill_cycles vs model", fill_cycles, 16'(m_busy_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound in case a wait never completes
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
